// File: rtl/ara_pkg.sv
// Shared types for the cluster request/response synchroniser: the cluster
// participation mask, the outstanding-count width and the empty-mask fixup.
package ara_pkg;

  localparam int unsigned MaxClusters  = 16;
  localparam int unsigned OutstandingW = 4;

  typedef logic [MaxClusters-1:0]  cluster_mask_t;
  typedef logic [OutstandingW-1:0] outstanding_t;

  // An empty participation mask would leave nobody to answer, so fall back to cluster 0.
  function automatic cluster_mask_t mask_fixup(cluster_mask_t m);
    return (m == '0) ? cluster_mask_t'(1) : m;
  endfunction

endpackage

// File: rtl/cluster_resp_slot.sv
// One per-cluster response capture register. It accepts a response while
// empty and enabled, and is emptied by the merged-response handshake.
module cluster_resp_slot
  import ara_pkg::*;
#(
  parameter int unsigned RespWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [RespWidth-1:0] result_i,
  input  logic                 error_i,
  input  logic                 clear_i,
  output logic                 ready_o,
  output logic                 full_o,
  output logic [RespWidth-1:0] result_o,
  output logic                 error_o
);

  logic                 full_q, full_d;
  logic [RespWidth-1:0] result_q;
  logic                 error_q;
  logic                 capture;

  // Disabled slots never accept; nothing is accepted while reset is held.
  assign ready_o  = en_i & ~full_q & ~rst_i;
  assign capture  = valid_i & ready_o;
  assign full_o   = full_q;
  assign result_o = result_q;
  assign error_o  = error_q;

  // Occupancy: a retire only hits full slots and a capture only empty ones.
  always_comb begin
    full_d = full_q;
    if (clear_i) full_d = 1'b0;
    if (capture) full_d = 1'b1;
  end

  // Occupancy register; partial joins are discarded by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  // Payload register; only meaningful while full, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      result_q <= result_i;
      error_q  <= error_i;
    end
  end

endmodule

// File: rtl/cluster_req_sync.sv
// Forks one upstream request to every enabled cluster and joins their
// responses into a single merged response, tracking outstanding requests.
// Optional feature: define CLUSTER_REQ_SYNC_CHECK_EN to add the sticky
// mismatch_o result-consistency flag.
module cluster_req_sync
  import ara_pkg::*;
#(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned RespWidth      = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrClusters-1:0]           cluster_en_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [ReqWidth-1:0]             req_data_i,
  output logic [NrClusters-1:0]           req_valid_o,
  input  logic [NrClusters-1:0]           req_ready_i,
  output logic [ReqWidth-1:0]             req_data_o,
  input  logic [NrClusters-1:0]           resp_valid_i,
  output logic [NrClusters-1:0]           resp_ready_o,
  input  logic [NrClusters*RespWidth-1:0] resp_result_i,
  input  logic [NrClusters-1:0]           resp_error_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [RespWidth-1:0]            resp_result_o,
  output logic                            resp_error_o,
  output logic [OutstandingW-1:0]         outstanding_o,
  output logic                            idle_o
`ifdef CLUSTER_REQ_SYNC_CHECK_EN
  ,
  output logic                            mismatch_o
`endif
);

  logic [NrClusters-1:0] en_q, en_d;
  logic [NrClusters-1:0] done_q, done_d;
  outstanding_t          out_q, out_d;
  logic [NrClusters-1:0] slot_full, slot_err;
  logic [RespWidth-1:0]  slot_res [NrClusters];
  logic                  can_issue, req_accept, resp_retire;

  // The upstream ready depends only on registered state and cluster readies,
  // never on req_valid_i.
  assign can_issue     = (out_q < outstanding_t'(MaxOutstanding));
  assign req_valid_o   = {NrClusters{req_valid_i & can_issue & ~rst_i}} & en_q & ~done_q;
  assign req_ready_o   = can_issue & ~rst_i & (&(done_q | ~en_q | req_ready_i));
  assign req_accept    = req_valid_i & req_ready_o;
  assign req_data_o    = req_data_i;
  assign resp_valid_o  = ~rst_i & (&(slot_full | ~en_q));
  assign resp_retire   = resp_valid_o & resp_ready_i;
  assign outstanding_o = out_q;
  assign idle_o        = (out_q == '0) & ~(|done_q) & ~(|slot_full);

  for (genvar c = 0; c < NrClusters; c++) begin : g_slot
    cluster_resp_slot #(
      .RespWidth(RespWidth)
    ) u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_q[c]),
      .valid_i  (resp_valid_i[c]),
      .result_i (resp_result_i[c*RespWidth +: RespWidth]),
      .error_i  (resp_error_i[c]),
      .clear_i  (resp_retire & en_q[c]),
      .ready_o  (resp_ready_o[c]),
      .full_o   (slot_full[c]),
      .result_o (slot_res[c]),
      .error_o  (slot_err[c])
    );
  end

  // Merge: result from the lowest-index enabled slot, error ORed across enabled slots.
  always_comb begin
    resp_result_o = '0;
    resp_error_o  = 1'b0;
    for (int c = NrClusters - 1; c >= 0; c--) begin
      if (en_q[c]) resp_result_o = slot_res[c];
    end
    for (int c = 0; c < NrClusters; c++) begin
      resp_error_o = resp_error_o | (en_q[c] & slot_err[c]);
    end
  end

  // Next state for fork progress, outstanding count and the participation mask.
  always_comb begin
    done_d = done_q | (req_valid_o & req_ready_i);
    if (req_accept) done_d = '0;
    out_d = out_q;
    case ({req_accept, resp_retire})
      2'b10:   out_d = out_q + outstanding_t'(1);
      2'b01:   out_d = out_q - outstanding_t'(1);
      default: out_d = out_q;
    endcase
    en_d = en_q;
    if (idle_o) en_d = NrClusters'(mask_fixup(cluster_mask_t'(cluster_en_i)));
  end

  // Control state; reset discards any partial fork and restores the full mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= '1;
      done_q <= '0;
      out_q  <= '0;
    end else begin
      en_q   <= en_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

`ifdef CLUSTER_REQ_SYNC_CHECK_EN
  logic mismatch_q, mismatch_d, res_differ;

  // Flag diverging cluster results at a merge, or a response nobody asked for.
  always_comb begin
    res_differ = 1'b0;
    for (int c = 0; c < NrClusters; c++) begin
      if (en_q[c] && (slot_res[c] != resp_result_o)) res_differ = 1'b1;
    end
    mismatch_d = mismatch_q;
    if (resp_retire && res_differ) mismatch_d = 1'b1;
    if ((|(resp_valid_i & resp_ready_o)) && (out_q == '0)) mismatch_d = 1'b1;
  end

  // Sticky flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mismatch_q <= 1'b0;
    else       mismatch_q <= mismatch_d;
  end

  assign mismatch_o = mismatch_q;
`endif

endmodule

// File: doc/cluster_req_sync.md
CLUSTER_REQ_SYNC -- requirements
Module: cluster_req_sync

Interface
REQ-001: Parameter NrClusters, default 4: number of Ara instances served; legal range 1..16.
REQ-002: Parameter MaxOutstanding, default 4: maximum requests broadcast but not yet answered; legal range 1..15.
REQ-003: Parameter ReqWidth, default 128: request payload width in bits.
REQ-004: Parameter RespWidth, default 64: response result width in bits.
REQ-005: clk_i  in  1  single clock; all logic rising-edge.
REQ-006: rst_i  in  1  reset, asynchronous, active-high.
REQ-007: cluster_en_i  in  NrClusters  requested participation mask.
REQ-008: req_valid_i / req_ready_o  in / out  1 / 1  upstream request handshake.
REQ-009: req_data_i  in  ReqWidth  request payload.
REQ-010: req_valid_o / req_ready_i  out / in  NrClusters / NrClusters  per-cluster request handshake.
REQ-011: req_data_o  out  ReqWidth  payload broadcast to all clusters, equal to req_data_i.
REQ-012: resp_valid_i / resp_ready_o  in / out  NrClusters / NrClusters  per-cluster response handshake.
REQ-013: resp_result_i / resp_error_i  in  NrClusters*RespWidth / NrClusters  per-cluster response result and error.
REQ-014: resp_valid_o / resp_ready_i  out / in  1 / 1  merged response handshake.
REQ-015: resp_result_o / resp_error_o  out  RespWidth / 1  merged response result and error.
REQ-016: outstanding_o  out  4  current outstanding count.
REQ-017: idle_o  out  1  high when the outstanding count is 0, no fork is partial, and no slot is full.

Function
REQ-018: Active mask en_q loads cluster_en_i only in cycles where idle_o=1; an all-zero cluster_en_i loads as bit 0 set.
REQ-019: Fork: per-cluster done flag; req_valid_o[c] = req_valid_i & en_q[c] & ~done[c] & (outstanding < MaxOutstanding).
REQ-020: done[c] sets on req_valid_o[c]&req_ready_i[c]; disabled clusters count as done.
REQ-021: req_ready_o = (outstanding < MaxOutstanding) & AND over c of (done[c] | ~en_q[c] | req_ready_i[c]); no combinational path from req_valid_i to req_ready_o.
REQ-022: On req_valid_i&req_ready_o, all done flags clear and outstanding increments; upstream must hold req_valid_i/req_data_i stable until accepted.
REQ-023: Response slot per cluster; resp_ready_o[c] = ~slot_full[c]; a handshake captures result and error, and slot_full is set the next cycle.
REQ-024: resp_valid_o = 1 when every en_q cluster has slot_full set; 1-cycle minimum latency from the last capture.
REQ-025: resp_result_o = slot result of the lowest-index enabled cluster; resp_error_o = OR of enabled slot errors.
REQ-026: On resp_valid_o&resp_ready_i, all enabled slots empty and outstanding decrements.
REQ-027: Same-cycle request accept and response retire leave outstanding unchanged; at MaxOutstanding a same-cycle retire does not unblock the request.
REQ-028: Slots of disabled clusters never fill; their resp_ready_o is 0.

Reset
REQ-029: While rst_i=1, all done flags and slots clear, outstanding=0, en_q=all ones, every req_valid_o and resp_valid_o is 0, and idle_o=1.
REQ-030: Reset asserted mid-fork or mid-join discards all partial state; no handshake completes in the reset cycle.

Configuration
REQ-031: Macro CLUSTER_REQ_SYNC_CHECK_EN defined: adds output mismatch_o (1 bit), sticky until reset, set when the results of enabled slots differ at a merged handshake, or when a response is captured with outstanding=0.
REQ-032: Macro undefined: mismatch_o is absent and there is no compare logic.

Structure
REQ-033: cluster_mask_t and the outstanding-count width constant reside in ara_pkg.
REQ-034: Sub-module cluster_resp_slot: one capture register with its handshake, instantiated NrClusters times.

Verification
REQ-035: NrClusters=4, all ready -> req accepted in 1 cycle, outstanding_o=1, each req_valid_o pulses once.
REQ-036: Cluster 2 ready 3 cycles late -> clusters 0,1,3 handshake once only; req_ready_o rises in the cycle cluster 2 is ready.
REQ-037: Responses arrive c3,c0,c1,c2 with results 0xA and c1 error=1 -> one merged response, result 0xA, error 1.
REQ-038: MaxOutstanding=2, 3 requests without responses -> third request stalls; it is accepted the cycle after the first merged response retires.
REQ-039: cluster_en_i=4'b0101 changed while busy -> old mask is held until idle; afterwards only clusters 0 and 2 are forked and joined. cluster_en_i=0 -> cluster 0 only.
REQ-040: Reset pulse mid-join -> all outputs return to reset values; with CLUSTER_REQ_SYNC_CHECK_EN defined, results 0x1/0x2 set mismatch_o.
